mem_responder: RTL and testbench



---
 rtl/sys_defs.sv | 26 ++
 rtl/mem_tag_alloc.sv | 49 ++++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared types for the processor/memory tag protocol.
package sys_defs;

  localparam int unsigned MEM_TAG_W   = 4;
  localparam int unsigned MEM_BLOCK_W = 64;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_COMMAND;

  typedef logic [MEM_TAG_W-1:0]   MEM_TAG;
  typedef logic [MEM_BLOCK_W-1:0] MEM_BLOCK;
  typedef logic [ADDR_W-1:0]      ADDR;

  // One outstanding load: countdown to its response plus the snapshot taken at acceptance.
  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] countdown;
    MEM_BLOCK         data;
  } MEM_RESP_ENTRY;

endpackage

// File: rtl/mem_tag_alloc.sv
// Busy vector for tags 1..NUM_TAGS with a lowest-free-tag priority encoder.
module mem_tag_alloc
  import sys_defs::*;
#(
  parameter int unsigned NUM_TAGS = 15
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   alloc,
  input  MEM_TAG rel_tag,
  output MEM_TAG free_tag_c,
  output logic   has_free_c,
  output logic   idle
);

  logic [NUM_TAGS:1] busy;
  logic [NUM_TAGS:1] busy_d;

  // Scan downwards so the lowest free tag is the last one written.
  always_comb begin
    free_tag_c = '0;
    has_free_c = 1'b0;
    for (int t = int'(NUM_TAGS); t >= 1; t--) begin
      if (!busy[t]) begin
        free_tag_c = MEM_TAG'(t);
        has_free_c = 1'b1;
      end
    end
  end

  always_comb begin
    busy_d = busy;
    for (int t = 1; t <= int'(NUM_TAGS); t++) begin
      if (alloc && has_free_c && (free_tag_c == MEM_TAG'(t))) busy_d[t] = 1'b1;
      if (rel_tag == MEM_TAG'(t)) busy_d[t] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
      idle <= 1'b1;
    end else begin
      busy <= busy_d;
      idle <= ~|busy_d;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency tagged memory responder for the proc2mem/mem2proc interface.
// Optional LFSR backpressure is enabled by defining MEM_RESP_BACKPRESSURE_EN.
module mem_responder
  import sys_defs::*;
#(
  parameter int unsigned NUM_TAGS           = 15,
  parameter int unsigned MEM_LATENCY_CYCLES = 4,
  parameter int unsigned MEM_DEPTH_BLOCKS   = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  MEM_COMMAND proc2mem_command,
  input  ADDR        proc2mem_addr,
  input  MEM_BLOCK   proc2mem_data,
  output MEM_TAG     mem2proc_transaction_tag,
  output MEM_TAG     mem2proc_data_tag,
  output MEM_BLOCK   mem2proc_data,
  output logic       mem_idle
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH_BLOCKS);

  MEM_BLOCK      mem [MEM_DEPTH_BLOCKS];
  MEM_RESP_ENTRY entries [1:NUM_TAGS];

  logic [IDX_W-1:0] idx_c;
  logic             unused_addr_c;
  MEM_TAG           free_tag_c;
  logic             has_free_c;
  logic             stall_c;
  logic             load_ok_c;
  logic             store_ok_c;
  MEM_TAG           fire_tag_c;
  MEM_BLOCK         fire_data_c;
  logic [MEM_TAG_W:0] fire_cnt_c;

  assign idx_c         = proc2mem_addr[3 +: IDX_W];
  assign unused_addr_c = ^{proc2mem_addr[ADDR_W-1:3+IDX_W], proc2mem_addr[2:0]};

`ifdef MEM_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall_c = (lfsr[1:0] == 2'b00);
`else
  assign stall_c = 1'b0;
`endif

  assign load_ok_c  = (proc2mem_command == MEM_LOAD) && has_free_c && !stall_c;
  assign store_ok_c = (proc2mem_command == MEM_STORE) && !stall_c;

  mem_tag_alloc #(
    .NUM_TAGS (NUM_TAGS)
  ) u_alloc (
    .clock      (clock),
    .reset      (reset),
    .alloc      (load_ok_c),
    .rel_tag    (mem2proc_data_tag),
    .free_tag_c (free_tag_c),
    .has_free_c (has_free_c),
    .idle       (mem_idle)
  );

  // Stores report a tag without consuming one; NUM_TAGS when the pool is empty.
  always_comb begin
    mem2proc_transaction_tag = '0;
    if (!reset) begin
      if (load_ok_c)       mem2proc_transaction_tag = free_tag_c;
      else if (store_ok_c) mem2proc_transaction_tag = has_free_c ? free_tag_c : MEM_TAG'(NUM_TAGS);
    end
  end

  // An entry at countdown 2 is one edge away from its response cycle; latency 1 bypasses the table.
  always_comb begin
    fire_tag_c  = '0;
    fire_data_c = '0;
    fire_cnt_c  = '0;
    for (int t = 1; t <= int'(NUM_TAGS); t++) begin
      if (entries[t].valid && (entries[t].countdown == CNT_W'(2))) begin
        fire_tag_c  = MEM_TAG'(t);
        fire_data_c = entries[t].data;
        fire_cnt_c  = fire_cnt_c + (MEM_TAG_W+1)'(1);
      end
    end
    if ((MEM_LATENCY_CYCLES == 1) && load_ok_c) begin
      fire_tag_c  = free_tag_c;
      fire_data_c = mem[idx_c];
      fire_cnt_c  = fire_cnt_c + (MEM_TAG_W+1)'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MEM_DEPTH_BLOCKS); i++) mem[i] <= '0;
      for (int t = 1; t <= int'(NUM_TAGS); t++) entries[t] <= '0;
      mem2proc_data_tag <= '0;
      mem2proc_data     <= '0;
    end else begin
      if (store_ok_c) mem[idx_c] <= proc2mem_data;
      for (int t = 1; t <= int'(NUM_TAGS); t++) begin
        if (entries[t].valid) begin
          if (entries[t].countdown > CNT_W'(1))
            entries[t].countdown <= entries[t].countdown - CNT_W'(1);
          // Free at the edge that ends the response cycle.
          if (mem2proc_data_tag == MEM_TAG'(t)) entries[t].valid <= 1'b0;
        end
        if (load_ok_c && (free_tag_c == MEM_TAG'(t)))
          entries[t] <= '{valid: 1'b1, countdown: CNT_W'(MEM_LATENCY_CYCLES), data: mem[idx_c]};
      end
      mem2proc_data_tag <= fire_tag_c;
      mem2proc_data     <= fire_data_c;
    end
  end

  always @(posedge clock) begin
    if (!reset) begin
      single_resp: assert (fire_cnt_c <= (MEM_TAG_W+1)'(1));
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default instance plus a two-tag instance for exhaustion.
module tb_mem_responder;
  import sys_defs::*;

  localparam MEM_BLOCK D1    = 64'hDEAD_BEEF_0123_4567;
  localparam MEM_BLOCK A0    = 64'h0000_0000_AAAA_0000;
  localparam MEM_BLOCK A8    = 64'h0000_0000_AAAA_0008;
  localparam MEM_BLOCK A10   = 64'h0000_0000_AAAA_0010;
  localparam MEM_BLOCK E18   = 64'hEEEE_1818_EEEE_1818;
  localparam MEM_BLOCK OLD   = 64'h0123_0123_0123_0123;
  localparam MEM_BLOCK NEW   = 64'h9876_9876_9876_9876;
  localparam MEM_BLOCK ALIAS = 64'hA11A_5A11_A5A1_1A5A;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  MEM_COMMAND cmd, cmd2;
  ADDR        addr, addr2;
  MEM_BLOCK   wdata, wdata2;
  MEM_TAG     tt, dtag, tt2, dtag2;
  MEM_BLOCK   rdata, rdata2;
  logic       idle, idle2;
  int         total = 0;
  int         bad = 0;

  always #5 clock = ~clock;

  mem_responder u_dut (
    .clock                    (clock),
    .reset                    (reset),
    .proc2mem_command         (cmd),
    .proc2mem_addr            (addr),
    .proc2mem_data            (wdata),
    .mem2proc_transaction_tag (tt),
    .mem2proc_data_tag        (dtag),
    .mem2proc_data            (rdata),
    .mem_idle                 (idle)
  );

  mem_responder #(.NUM_TAGS(2)) u_dut2 (
    .clock                    (clock),
    .reset                    (reset),
    .proc2mem_command         (cmd2),
    .proc2mem_addr            (addr2),
    .proc2mem_data            (wdata2),
    .mem2proc_transaction_tag (tt2),
    .mem2proc_data_tag        (dtag2),
    .mem2proc_data            (rdata2),
    .mem_idle                 (idle2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply a command to the default instance for one cycle; return mid-cycle.
  task automatic step(input MEM_COMMAND c, input ADDR a, input MEM_BLOCK d);
    @(posedge clock);
    #1;
    cmd = c; addr = a; wdata = d;
    cmd2 = MEM_NONE;
    @(negedge clock);
  endtask

  task automatic step2(input MEM_COMMAND c, input ADDR a, input MEM_BLOCK d);
    @(posedge clock);
    #1;
    cmd2 = c; addr2 = a; wdata2 = d;
    cmd = MEM_NONE;
    @(negedge clock);
  endtask

  initial begin
    cmd = MEM_LOAD; addr = '0; wdata = '0;
    cmd2 = MEM_STORE; addr2 = '0; wdata2 = '0;
    @(negedge clock);
    chk("rst_tt", 64'(tt), 64'd0);
    chk("rst_tt2", 64'(tt2), 64'd0);
    chk("rst_dtag", 64'(dtag), 64'd0);
    chk("rst_data", rdata, 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b0; cmd = MEM_NONE; cmd2 = MEM_NONE;

    // store then load, fixed latency
    step(MEM_STORE, 32'h40, D1);  chk("st_tt", 64'(tt), 64'd1); chk("st_idle", 64'(idle), 64'd1);
    step(MEM_LOAD, 32'h40, '0);   chk("ld_tt", 64'(tt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(MEM_NONE, '0, '0);
      chk("ld_wait_dtag", 64'(dtag), 64'd0);
      chk("ld_wait_idle", 64'(idle), 64'd0);
    end
    step(MEM_NONE, '0, '0);
    chk("ld_dtag", 64'(dtag), 64'd1); chk("ld_data", rdata, D1); chk("ld_resp_idle", 64'(idle), 64'd0);
    step(MEM_NONE, '0, '0);
    chk("ld_after_dtag", 64'(dtag), 64'd0); chk("ld_after_idle", 64'(idle), 64'd1);

    // three back-to-back loads
    step(MEM_STORE, 32'h00, A0);  chk("st0_tt", 64'(tt), 64'd1);
    step(MEM_STORE, 32'h08, A8);  chk("st8_tt", 64'(tt), 64'd1);
    step(MEM_STORE, 32'h10, A10); chk("st10_tt", 64'(tt), 64'd1);
    step(MEM_LOAD, 32'h00, '0);   chk("b2b_tt1", 64'(tt), 64'd1);
    step(MEM_LOAD, 32'h08, '0);   chk("b2b_tt2", 64'(tt), 64'd2);
    step(MEM_LOAD, 32'h10, '0);   chk("b2b_tt3", 64'(tt), 64'd3);
    step(MEM_NONE, '0, '0);       chk("b2b_gap", 64'(dtag), 64'd0);
    step(MEM_NONE, '0, '0);       chk("b2b_dtag1", 64'(dtag), 64'd1); chk("b2b_data1", rdata, A0);
    step(MEM_NONE, '0, '0);       chk("b2b_dtag2", 64'(dtag), 64'd2); chk("b2b_data2", rdata, A8);
    step(MEM_NONE, '0, '0);       chk("b2b_dtag3", 64'(dtag), 64'd3); chk("b2b_data3", rdata, A10);
    step(MEM_NONE, '0, '0);       chk("b2b_end", 64'(dtag), 64'd0); chk("b2b_idle", 64'(idle), 64'd1);

    // tag exhaustion on the two-tag instance
    step2(MEM_STORE, 32'h18, E18); chk("x_st_tt", 64'(tt2), 64'd1);
    step2(MEM_LOAD, 32'h18, '0);   chk("x_tt_c1", 64'(tt2), 64'd1);
    step2(MEM_LOAD, 32'h18, '0);   chk("x_tt_c2", 64'(tt2), 64'd2);
    step2(MEM_LOAD, 32'h18, '0);   chk("x_tt_c3", 64'(tt2), 64'd0);
    step2(MEM_STORE, 32'h20, '0);  chk("x_st_full", 64'(tt2), 64'd2);
    step2(MEM_LOAD, 32'h18, '0);   chk("x_tt_c5", 64'(tt2), 64'd0);
    chk("x_dtag_c5", 64'(dtag2), 64'd1); chk("x_data_c5", rdata2, E18);
    step2(MEM_LOAD, 32'h18, '0);   chk("x_retry_tt", 64'(tt2), 64'd1);
    chk("x_dtag_c6", 64'(dtag2), 64'd2); chk("x_data_c6", rdata2, E18);
    for (int i = 0; i < 3; i++) step2(MEM_NONE, '0, '0);
    step2(MEM_NONE, '0, '0);       chk("x_retry_dtag", 64'(dtag2), 64'd1);
    step2(MEM_NONE, '0, '0);       chk("x_idle", 64'(idle2), 64'd1);

    // load snapshot precedes a later store to the same block
    step(MEM_STORE, 32'h80, OLD); chk("hz_st_tt", 64'(tt), 64'd1);
    step(MEM_LOAD, 32'h80, '0);   chk("hz_ld_tt", 64'(tt), 64'd1);
    step(MEM_STORE, 32'h80, NEW); chk("hz_st2_tt", 64'(tt), 64'd2);
    step(MEM_NONE, '0, '0);
    step(MEM_NONE, '0, '0);
    step(MEM_NONE, '0, '0);       chk("hz_dtag", 64'(dtag), 64'd1); chk("hz_old", rdata, OLD);
    step(MEM_LOAD, 32'h80, '0);   chk("hz_ld2_tt", 64'(tt), 64'd1);
    for (int i = 0; i < 3; i++) step(MEM_NONE, '0, '0);
    step(MEM_NONE, '0, '0);       chk("hz_dtag2", 64'(dtag), 64'd1); chk("hz_new", rdata, NEW);
    step(MEM_NONE, '0, '0);       chk("hz_idle", 64'(idle), 64'd1);

    // address aliasing wraps above the storage depth
    step(MEM_STORE, 32'h800, ALIAS); chk("al_st_tt", 64'(tt), 64'd1);
    step(MEM_LOAD, 32'h000, '0);     chk("al_ld_tt", 64'(tt), 64'd1);
    for (int i = 0; i < 3; i++) step(MEM_NONE, '0, '0);
    step(MEM_NONE, '0, '0);          chk("al_dtag", 64'(dtag), 64'd1); chk("al_data", rdata, ALIAS);

    // reset with loads in flight
    step(MEM_LOAD, 32'h00, '0);   chk("rp_tt1", 64'(tt), 64'd1);
    step(MEM_LOAD, 32'h08, '0);   chk("rp_tt2", 64'(tt), 64'd2);
    step(MEM_LOAD, 32'h10, '0);   chk("rp_tt3", 64'(tt), 64'd3);
    @(posedge clock);
    #1;
    reset = 1'b1; cmd = MEM_LOAD; addr = '0;
    @(negedge clock);
    chk("rp_rst_tt", 64'(tt), 64'd0);
    chk("rp_rst_dtag", 64'(dtag), 64'd0);
    chk("rp_rst_idle", 64'(idle), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b0; cmd = MEM_NONE;
    for (int i = 0; i < 6; i++) begin
      step(MEM_NONE, '0, '0);
      chk("rp_no_dtag", 64'(dtag), 64'd0);
      chk("rp_idle", 64'(idle), 64'd1);
    end
    step(MEM_LOAD, 32'h10, '0);   chk("rp_new_tt", 64'(tt), 64'd1);
    for (int i = 0; i < 3; i++) step(MEM_NONE, '0, '0);
    step(MEM_NONE, '0, '0);       chk("rp_new_dtag", 64'(dtag), 64'd1); chk("rp_cleared", rdata, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
